// File: rtl/punc_pkg.sv
// Shared constants for the multi-cycle PUnC LC3 control: opcodes, datapath
// select encodings and FSM state codes.
package punc_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam int BR_N    = 11;
    localparam int BR_Z    = 10;
    localparam int BR_P    = 9;
    localparam int IMM_BIT = 5;
    localparam int JSR_BIT = 11;

    localparam logic [7:0] TRAP_HALT_VEC = 8'h25;

    localparam logic [1:0] MEM_R_ADDR_SEL_PC      = 2'd0;
    localparam logic [1:0] MEM_R_ADDR_SEL_ALU     = 2'd1;
    localparam logic [1:0] MEM_R_ADDR_SEL_LDI_REG = 2'd2;
    localparam logic [1:0] MEM_R_ADDR_SEL_C       = 2'd3;

    localparam logic [1:0] MEM_W_ADDR_SEL_ALU     = 2'd1;
    localparam logic [1:0] MEM_W_ADDR_SEL_LDI_REG = 2'd2;

    localparam logic       MEM_W_DATA_SEL_RF0 = 1'b0;
    localparam logic       MEM_W_DATA_SEL_RF1 = 1'b1;

    localparam logic       RF_W_ADDR_SEL_A = 1'b0;   // ir[11:9]
    localparam logic       RF_W_ADDR_SEL_B = 1'b1;   // R7
    localparam logic [1:0] RF_W_DATA_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_W_DATA_SEL_MEM = 2'd1;
    localparam logic [1:0] RF_W_DATA_SEL_PC  = 2'd2;
    localparam logic       RF_R0_ADDR_SEL_A = 1'b0;  // ir[8:6]
    localparam logic       RF_R0_ADDR_SEL_B = 1'b1;  // ir[11:9]
    localparam logic       RF_R1_ADDR_SEL_A = 1'b0;  // ir[2:0]
    localparam logic       RF_R1_ADDR_SEL_B = 1'b1;  // ir[11:9]

    localparam logic [1:0] PC_LD_DATA_SEL_ALU      = 2'd0;
    localparam logic [1:0] PC_LD_DATA_SEL_RF       = 2'd1;
    localparam logic [1:0] PC_LD_DATA_SEL_LDI_REG  = 2'd2;
    localparam logic [1:0] PC_LD_DATA_SEL_PC_OFF11 = 2'd3;

    localparam logic [2:0] ALU_ADD_R     = 3'd0;
    localparam logic [2:0] ALU_ADD_I     = 3'd1;
    localparam logic [2:0] ALU_AND_R     = 3'd2;
    localparam logic [2:0] ALU_AND_I     = 3'd3;
    localparam logic [2:0] ALU_NOT       = 3'd4;
    localparam logic [2:0] ALU_PC_OFF9   = 3'd5;
    localparam logic [2:0] ALU_BASE_OFF6 = 3'd6;
    localparam logic [2:0] ALU_PASS      = 3'd7;

    localparam logic COND_LD_DATA_SEL_ALU = 1'b0;
    localparam logic COND_LD_DATA_SEL_RF  = 1'b1;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_EXEC2  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    function automatic logic br_taken(input logic [15:0] ir, input logic n,
                                      input logic z, input logic p);
        return (n & ir[BR_N]) | (z & ir[BR_Z]) | (p & ir[BR_P]);
    endfunction

endpackage

// File: rtl/punc_mem_timeout.sv
// Memory-handshake watchdog: counts consecutive un-acked request cycles and
// flags the cycle that would make the count reach TIMEOUT_CYCLES.
module punc_mem_timeout #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ack,
    output logic timeout_hit
);

    logic [TO_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (!mem_req || mem_ack)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign timeout_hit = 1'b0;
        end else begin : g_on
            // The current un-acked cycle is the one that brings the count to the threshold.
            localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);
            assign timeout_hit = mem_req && !mem_ack && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/punc_control_mc.sv
// Multi-cycle PUnC LC3 control FSM with req/ack memory and timeout fault.
// Define PUNC_TRAP_EN to run TRAP vectors other than x25 as an indirect jump.
module punc_control_mc
    import punc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        ldi_reg_ld,
    output logic        halted,
    output logic        fault
);

    logic [2:0] state, next_state;
    logic [3:0] opcode;
    logic       timeout_hit;
    logic       trap_run;
    logic       unused_ir;

    assign opcode = ir[15:12];
    // Operand fields feed the datapath directly; only steering bits matter here.
    assign unused_ir = ^ir;

`ifdef PUNC_TRAP_EN
    assign trap_run = (opcode == OP_TRAP) && (ir[7:0] != TRAP_HALT_VEC);
`else
    assign trap_run = 1'b0;
`endif

    punc_mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .timeout_hit(timeout_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_INIT;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: every output and next_state gets a default first, so no path can infer a latch.
        mem_req = 1'b0;          mem_w_en = 1'b0;
        mem_w_addr_sel = '0;     mem_w_data_sel = MEM_W_DATA_SEL_RF0;
        mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
        rf_w_en = 1'b0;          rf_w_addr_sel = RF_W_ADDR_SEL_A;
        rf_w_data_sel = RF_W_DATA_SEL_ALU;
        rf_r0_addr_sel = RF_R0_ADDR_SEL_A;
        rf_r1_addr_sel = RF_R1_ADDR_SEL_A;
        ir_ld = 1'b0;  pc_ld = 1'b0;  pc_clr = 1'b0;  pc_inc = 1'b0;
        pc_ld_data_sel = PC_LD_DATA_SEL_ALU;
        alu_sel = ALU_ADD_R;
        cond_ld = 1'b0;          cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
        ldi_reg_ld = 1'b0;       halted = 1'b0;   fault = 1'b0;
        next_state = state;

        case (state)
            S_INIT: begin
                pc_clr     = 1'b1;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_ld      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_inc     = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                next_state = S_FETCH;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
                        rf_w_en = 1'b1;
                        cond_ld = 1'b1;
                        if (opcode == OP_NOT)      alu_sel = ALU_NOT;
                        else if (opcode == OP_LEA) alu_sel = ALU_PC_OFF9;
                        else if (opcode == OP_ADD) alu_sel = ir[IMM_BIT] ? ALU_ADD_I : ALU_ADD_R;
                        else                       alu_sel = ir[IMM_BIT] ? ALU_AND_I : ALU_AND_R;
                    end
                    OP_BR: begin
                        alu_sel = ALU_PC_OFF9;
                        pc_ld   = br_taken(ir, n, z, p);
                    end
                    OP_JMP: begin
                        pc_ld          = 1'b1;
                        pc_ld_data_sel = PC_LD_DATA_SEL_RF;
                    end
                    OP_JSR: begin
                        rf_w_en        = 1'b1;
                        rf_w_addr_sel  = RF_W_ADDR_SEL_B;
                        rf_w_data_sel  = RF_W_DATA_SEL_PC;
                        pc_ld          = 1'b1;
                        pc_ld_data_sel = ir[JSR_BIT] ? PC_LD_DATA_SEL_PC_OFF11 : PC_LD_DATA_SEL_RF;
                    end
                    OP_LD, OP_LDR, OP_LDI, OP_STI: begin
                        mem_req        = 1'b1;
                        mem_r_addr_sel = MEM_R_ADDR_SEL_ALU;
                        alu_sel        = (opcode == OP_LDR) ? ALU_BASE_OFF6 : ALU_PC_OFF9;
                        if (!mem_ack) begin
                            next_state = S_EXEC;
                        end else if (opcode == OP_LDI || opcode == OP_STI) begin
                            ldi_reg_ld = 1'b1;
                            next_state = S_EXEC2;
                        end else begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = RF_W_DATA_SEL_MEM;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = COND_LD_DATA_SEL_RF;
                        end
                    end
                    OP_ST, OP_STR: begin
                        mem_req        = 1'b1;
                        mem_w_addr_sel = MEM_W_ADDR_SEL_ALU;
                        mem_w_en       = mem_ack;
                        if (opcode == OP_STR) begin
                            alu_sel        = ALU_BASE_OFF6;
                            rf_r1_addr_sel = RF_R1_ADDR_SEL_B;
                            mem_w_data_sel = MEM_W_DATA_SEL_RF1;
                        end else begin
                            alu_sel        = ALU_PC_OFF9;
                            rf_r0_addr_sel = RF_R0_ADDR_SEL_B;
                        end
                        if (!mem_ack) next_state = S_EXEC;
                    end
                    OP_TRAP: begin
                        if (trap_run) begin
                            mem_req        = 1'b1;
                            mem_r_addr_sel = MEM_R_ADDR_SEL_C;
                            next_state     = S_EXEC;
                            if (mem_ack) begin
                                rf_w_en       = 1'b1;
                                rf_w_addr_sel = RF_W_ADDR_SEL_B;
                                rf_w_data_sel = RF_W_DATA_SEL_PC;
                                ldi_reg_ld    = 1'b1;
                                next_state    = S_EXEC2;
                            end
                        end else begin
                            next_state = S_HALT;
                        end
                    end
                    default: next_state = S_HALT;   // RTI and reserved 1101
                endcase
            end
            S_EXEC2: begin
                if (trap_run) begin
                    pc_ld          = 1'b1;
                    pc_ld_data_sel = PC_LD_DATA_SEL_LDI_REG;
                    next_state     = S_FETCH;
                end else begin
                    mem_req        = 1'b1;
                    mem_r_addr_sel = MEM_R_ADDR_SEL_LDI_REG;
                    mem_w_addr_sel = MEM_W_ADDR_SEL_LDI_REG;
                    if (opcode == OP_STI) begin
                        rf_r0_addr_sel = RF_R0_ADDR_SEL_B;
                        mem_w_en       = mem_ack;
                    end else if (mem_ack) begin
                        rf_w_en          = 1'b1;
                        rf_w_data_sel    = RF_W_DATA_SEL_MEM;
                        cond_ld          = 1'b1;
                        cond_ld_data_sel = COND_LD_DATA_SEL_RF;
                    end
                    if (mem_ack) next_state = S_FETCH;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: next_state = S_INIT;
        endcase

        // An ack in the threshold cycle clears timeout_hit, so completion wins.
        if (timeout_hit) next_state = S_FAULT;
    end

endmodule

// File: tb/tb_punc_control_mc.sv
// Self-checking bench for punc_control_mc (TIMEOUT_CYCLES=4): a cycle-by-cycle
// vector table from reset plus hand sequences for waits, timeout, reset and TRAP.
module tb_punc_control_mc;
    import punc_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       ldi_reg_ld;
        logic       halted;
        logic       fault;
    } ctl_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic        ack;
        ctl_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n, z, p, mem_ack;
    logic        mem_req, mem_w_en, mem_w_data_sel, rf_w_en, rf_w_addr_sel;
    logic [1:0]  mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic        rf_r0_addr_sel, rf_r1_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc;
    logic [2:0]  alu_sel;
    logic        cond_ld, cond_ld_data_sel, ldi_reg_ld, halted, fault;
    ctl_t        act;

    int n_checks = 0;
    int n_err    = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    punc_control_mc #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel),
        .mem_w_data_sel(mem_w_data_sel), .mem_r_addr_sel(mem_r_addr_sel),
        .rf_w_en(rf_w_en), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_data_sel(rf_w_data_sel),
        .rf_r0_addr_sel(rf_r0_addr_sel), .rf_r1_addr_sel(rf_r1_addr_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
        .pc_ld_data_sel(pc_ld_data_sel), .alu_sel(alu_sel), .cond_ld(cond_ld),
        .cond_ld_data_sel(cond_ld_data_sel), .ldi_reg_ld(ldi_reg_ld),
        .halted(halted), .fault(fault)
    );

    assign act = {mem_req, mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
                  rf_w_en, rf_w_addr_sel, rf_w_data_sel, rf_r0_addr_sel, rf_r1_addr_sel,
                  ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel, cond_ld,
                  cond_ld_data_sel, ldi_reg_ld, halted, fault};

    task automatic check(input string name, input ctl_t got, input ctl_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    function automatic ctl_t e_init();
        ctl_t e = '0;
        e.pc_clr = 1'b1;
        return e;
    endfunction

    function automatic ctl_t e_fetch(input logic ack);
        ctl_t e = '0;
        e.mem_req        = 1'b1;
        e.mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
        e.ir_ld          = ack;
        return e;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t e = '0;
        e.pc_inc = 1'b1;
        return e;
    endfunction

    function automatic ctl_t e_ld(input logic ack, input logic [2:0] asel);
        ctl_t e = '0;
        e.mem_req        = 1'b1;
        e.mem_r_addr_sel = MEM_R_ADDR_SEL_ALU;
        e.alu_sel        = asel;
        if (ack) begin
            e.rf_w_en          = 1'b1;
            e.rf_w_data_sel    = RF_W_DATA_SEL_MEM;
            e.cond_ld          = 1'b1;
            e.cond_ld_data_sel = COND_LD_DATA_SEL_RF;
        end
        return e;
    endfunction

    function automatic ctl_t e_flag(input logic h, input logic f);
        ctl_t e = '0;
        e.halted = h;
        e.fault  = f;
        return e;
    endfunction

    task automatic add(input string nm, input logic [15:0] i, input logic [2:0] nzp,
                       input logic ack, input ctl_t e);
        vec_t v;
        v.name = nm; v.ir = i; v.nzp = nzp; v.ack = ack; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add_fd(input string nm, input logic [15:0] i, input logic [2:0] nzp);
        add({nm, " fetch"}, i, nzp, 1'b1, e_fetch(1'b1));
        add({nm, " decode"}, i, nzp, 1'b0, e_decode());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic ack);
        ir = i;
        mem_ack = ack;
        @(negedge clk);
    endtask

    // Holds reset across one edge, checks INIT outputs, releases at posedge+1.
    task automatic do_reset();
        rst = 1'b0; mem_ack = 1'b0; ir = 16'h0000; {n, z, p} = 3'b000;
        tick();
        @(negedge clk);
        check("reset held", act, e_init());
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        ctl_t e;
        logic [7:0] pat;
        int ldi_cnt, rf_cnt, early, ldi_idx, rf_idx;

        // Cycle-by-cycle trace from reset release.
        add("init", 16'h0000, 3'b000, 1'b0, e_init());

        add_fd("add_i", 16'h1263, 3'b000);
        e = '0; e.rf_w_en = 1; e.rf_w_data_sel = RF_W_DATA_SEL_ALU; e.alu_sel = ALU_ADD_I;
        e.cond_ld = 1; e.cond_ld_data_sel = COND_LD_DATA_SEL_ALU;
        add("add_i exec", 16'h1263, 3'b000, 1'b1, e);

        add_fd("brz z0", 16'h0405, 3'b100);
        e = '0; e.alu_sel = ALU_PC_OFF9;
        add("brz z0 exec", 16'h0405, 3'b100, 1'b1, e);

        add_fd("brz z1", 16'h0405, 3'b010);
        e = '0; e.alu_sel = ALU_PC_OFF9; e.pc_ld = 1; e.pc_ld_data_sel = PC_LD_DATA_SEL_ALU;
        add("brz z1 exec", 16'h0405, 3'b010, 1'b1, e);

        add_fd("sti", 16'hB602, 3'b000);
        e = '0; e.mem_req = 1; e.mem_r_addr_sel = MEM_R_ADDR_SEL_ALU; e.alu_sel = ALU_PC_OFF9;
        e.ldi_reg_ld = 1;
        add("sti exec", 16'hB602, 3'b000, 1'b1, e);
        e = '0; e.mem_req = 1; e.mem_r_addr_sel = MEM_R_ADDR_SEL_LDI_REG;
        e.mem_w_addr_sel = MEM_W_ADDR_SEL_LDI_REG; e.mem_w_en = 1;
        e.mem_w_data_sel = MEM_W_DATA_SEL_RF0; e.rf_r0_addr_sel = RF_R0_ADDR_SEL_B;
        add("sti exec2", 16'hB602, 3'b000, 1'b1, e);

        add_fd("ldr", 16'h64C5, 3'b000);
        add("ldr exec wait", 16'h64C5, 3'b000, 1'b0, e_ld(1'b0, ALU_BASE_OFF6));
        add("ldr exec ack", 16'h64C5, 3'b000, 1'b1, e_ld(1'b1, ALU_BASE_OFF6));

        add_fd("st", 16'h3A10, 3'b000);
        e = '0; e.mem_req = 1; e.mem_w_addr_sel = MEM_W_ADDR_SEL_ALU; e.alu_sel = ALU_PC_OFF9;
        e.rf_r0_addr_sel = RF_R0_ADDR_SEL_B; e.mem_w_data_sel = MEM_W_DATA_SEL_RF0; e.mem_w_en = 1;
        add("st exec", 16'h3A10, 3'b000, 1'b1, e);

        add_fd("str", 16'h7283, 3'b000);
        e = '0; e.mem_req = 1; e.mem_w_addr_sel = MEM_W_ADDR_SEL_ALU; e.alu_sel = ALU_BASE_OFF6;
        e.rf_r1_addr_sel = RF_R1_ADDR_SEL_B; e.mem_w_data_sel = MEM_W_DATA_SEL_RF1; e.mem_w_en = 1;
        add("str exec", 16'h7283, 3'b000, 1'b1, e);

        add_fd("not", 16'h96BF, 3'b000);
        e = '0; e.rf_w_en = 1; e.alu_sel = ALU_NOT; e.cond_ld = 1;
        add("not exec", 16'h96BF, 3'b000, 1'b1, e);

        add("and fetch wait", 16'h5283, 3'b000, 1'b0, e_fetch(1'b0));
        add_fd("and_r", 16'h5283, 3'b000);
        e = '0; e.rf_w_en = 1; e.alu_sel = ALU_AND_R; e.cond_ld = 1;
        add("and_r exec", 16'h5283, 3'b000, 1'b1, e);

        add_fd("jsr", 16'h4805, 3'b000);
        e = '0; e.rf_w_en = 1; e.rf_w_addr_sel = RF_W_ADDR_SEL_B; e.rf_w_data_sel = RF_W_DATA_SEL_PC;
        e.pc_ld = 1; e.pc_ld_data_sel = PC_LD_DATA_SEL_PC_OFF11;
        add("jsr exec", 16'h4805, 3'b000, 1'b1, e);

        add_fd("jsrr", 16'h4080, 3'b000);
        e.pc_ld_data_sel = PC_LD_DATA_SEL_RF;
        add("jsrr exec", 16'h4080, 3'b000, 1'b1, e);

        add_fd("jmp", 16'hC080, 3'b000);
        e = '0; e.pc_ld = 1; e.pc_ld_data_sel = PC_LD_DATA_SEL_RF;
        add("jmp exec", 16'hC080, 3'b000, 1'b1, e);

        add_fd("lea", 16'hE803, 3'b000);
        e = '0; e.rf_w_en = 1; e.alu_sel = ALU_PC_OFF9; e.cond_ld = 1;
        add("lea exec", 16'hE803, 3'b000, 1'b1, e);

        add_fd("rsv", 16'hD000, 3'b000);
        add("rsv exec", 16'hD000, 3'b000, 1'b1, '0);
        add("halt 1", 16'h1263, 3'b000, 1'b1, e_flag(1'b1, 1'b0));
        add("halt 2", 16'h0405, 3'b111, 1'b1, e_flag(1'b1, 1'b0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            {n, z, p} = vecs[i].nzp;
            drive(vecs[i].ir, vecs[i].ack);
            check(vecs[i].name, act, vecs[i].exp);
            tick();
        end

        // LDI, two wait cycles per phase: F D E E E E2 E2 E2 = 8 cycles.
        do_reset();
        drive(16'h0000, 1'b0); tick();          // INIT
        pat = 8'b1001_0001;
        ldi_cnt = 0; rf_cnt = 0; early = 0; ldi_idx = -1; rf_idx = -1;
        for (int c = 0; c < 8; c++) begin
            drive(16'hA405, pat[c]);
            if (ldi_reg_ld) begin ldi_cnt++; ldi_idx = c; end
            if (rf_w_en)    begin rf_cnt++;  rf_idx  = c; end
            if (!pat[c] && (rf_w_en | cond_ld | ldi_reg_ld | mem_w_en | ir_ld | pc_ld))
                early++;
            tick();
        end
        check_int("ldi ldi_reg_ld pulses", ldi_cnt, 1);
        check_int("ldi rf_w_en pulses", rf_cnt, 1);
        check_int("ldi strobes without ack", early, 0);
        check_int("ldi ldi_reg_ld cycle", ldi_idx, 4);
        check_int("ldi rf_w_en cycle", rf_idx, 7);
        drive(16'hA405, 1'b0);
        check("ldi back in fetch", act, e_fetch(1'b0));

        // Timeout: four un-acked FETCH cycles, then FAULT.
        do_reset();
        drive(16'h0000, 1'b0); tick();
        for (int c = 0; c < 4; c++) begin
            drive(16'h1263, 1'b0);
            check($sformatf("timeout wait %0d", c), act, e_fetch(1'b0));
            tick();
        end
        drive(16'h1263, 1'b0);
        check("timeout fault", act, e_flag(1'b0, 1'b1));
        tick();
        drive(16'h1263, 1'b1);
        check("fault sticky", act, e_flag(1'b0, 1'b1));
        #1 rst = 1'b0;
        #1 check("reset leaves fault", act, e_init());
        tick();
        rst = 1'b1;
        drive(16'h1263, 1'b0);
        check("recover init", act, e_init());
        tick();
        drive(16'h1263, 1'b0);
        check("recover fetch", act, e_fetch(1'b0));

        // Ack in the threshold cycle wins, in FETCH and again in EXEC.
        do_reset();
        drive(16'h0000, 1'b0); tick();
        for (int c = 0; c < 3; c++) begin drive(16'h2205, 1'b0); tick(); end
        drive(16'h2205, 1'b1);
        check("fetch ack at threshold", act, e_fetch(1'b1));
        tick();
        drive(16'h2205, 1'b0);
        check("ld decode", act, e_decode());
        tick();
        for (int c = 0; c < 3; c++) begin drive(16'h2205, 1'b0); tick(); end
        drive(16'h2205, 1'b1);
        check("ld ack at threshold", act, e_ld(1'b1, ALU_PC_OFF9));
        tick();
        drive(16'h2205, 1'b0);
        check("ld no fault", act, e_fetch(1'b0));
        #1 rst = 1'b0;
        #1 check("reset drops mem_req", act, e_init());
        tick();
        rst = 1'b1;

        // TRAP x20 then (with the feature) TRAP x25.
        do_reset();
        drive(16'h0000, 1'b0); tick();
        drive(16'hF020, 1'b1); check("trap20 fetch", act, e_fetch(1'b1)); tick();
        drive(16'hF020, 1'b0); check("trap20 decode", act, e_decode()); tick();
`ifdef PUNC_TRAP_EN
        drive(16'hF020, 1'b1);
        e = '0; e.mem_req = 1; e.mem_r_addr_sel = MEM_R_ADDR_SEL_C; e.rf_w_en = 1;
        e.rf_w_addr_sel = RF_W_ADDR_SEL_B; e.rf_w_data_sel = RF_W_DATA_SEL_PC; e.ldi_reg_ld = 1;
        check("trap20 exec", act, e);
        tick();
        drive(16'hF020, 1'b1);
        e = '0; e.pc_ld = 1; e.pc_ld_data_sel = PC_LD_DATA_SEL_LDI_REG;
        check("trap20 exec2", act, e);
        tick();
        drive(16'hF025, 1'b1); check("trap25 fetch", act, e_fetch(1'b1)); tick();
        drive(16'hF025, 1'b0); check("trap25 decode", act, e_decode()); tick();
        drive(16'hF025, 1'b1); check("trap25 exec", act, '0); tick();
`else
        drive(16'hF020, 1'b1); check("trap20 exec", act, '0); tick();
`endif
        for (int c = 0; c < 3; c++) begin
            drive(16'hF020, 1'b1);
            check($sformatf("trap halted %0d", c), act, e_flag(1'b1, 1'b0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
